// File: rtl/adc_stream_pkg.sv
// Shared states, command bytes and framing constants for the ADC capture streamer.
package adc_stream_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADCRST = 3'd1,
        S_CAL    = 3'd2,
        S_CAP    = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    localparam logic [7:0] CMD_START = 8'h53;
    localparam logic [7:0] CMD_ABORT = 8'h41;
    localparam logic [7:0] SYNC0     = 8'hA5;
    localparam logic [7:0] SYNC1     = 8'h5A;

    function automatic int bytes_per_sample(input int n_bit);
        return (n_bit > 8) ? 2 : 1;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Synchronous show-ahead FIFO for captured sample words; a flush empties it in one cycle.
module adc_sample_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/adc_capture_streamer.sv
// ADC reset/calibrate/capture sequencer streaming samples byte-wise to a UART transmitter.
// Optional framing (sync header + XOR checksum) is enabled by defining ADC_STREAM_FRAME_EN.
module adc_capture_streamer
    import adc_stream_pkg::*;
#(
    parameter int N_BIT       = 6,
    parameter int N_CH        = 1,
    parameter int NUM_SAMPLED = 102400,
    parameter int FIFO_DEPTH  = 16,
    parameter int RST_CYC     = 16,
    parameter int CAL_CYC     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_vld,
    input  logic [7:0]            rx_data,
    input  logic                  tx_rdy,
    output logic                  tx_wreq,
    output logic [7:0]            tx_wdata,
    input  logic                  adc_ack,
    input  logic [N_CH*N_BIT-1:0] adc_dout,
    output logic                  rstn_adc,
    output logic                  calib_ena,
    output logic                  adc_ena,
    output logic                  busy,
    output logic                  ovf,
    output logic [2:0]            state_o,
    output logic [17:0]           cnt_sent
);
    localparam int W      = N_CH * N_BIT;
    localparam int BPS    = bytes_per_sample(N_BIT);
    localparam int NBYTES = N_CH * BPS;
    localparam int SW     = $clog2(NUM_SAMPLED + 1);
    localparam int CMAX   = (RST_CYC > CAL_CYC) ? RST_CYC : CAL_CYC;
    localparam int CW     = $clog2(CMAX + 1);
    localparam logic [3:0]    LAST_IDX = 4'(NBYTES - 1);
    localparam logic [SW-1:0] LAST_SMP = SW'(NUM_SAMPLED - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] CAL_LAST = CW'(CAL_CYC - 1);

    state_t        state;
    logic          ack_p0, ack_p1;
    logic [W-1:0]  dout_p0;
    logic [CW-1:0] cyc_cnt;
    logic [SW-1:0] smp_cnt;
    logic          ser_busy;
    logic [3:0]    ser_idx;
    logic [W-1:0]  ser_word;
    logic [W-1:0]  fifo_rdata;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic          cmd_start, cmd_abort, streaming, can_issue, edge_cap;
    logic          issue_sample, hdr_idle, frame_done, drain_done;
    logic [W-1:0]  src_word;
    logic [3:0]    src_idx;
    logic [7:0]    sample_byte;

    // Byte idx of a word: channel idx/BPS, LSB byte first, zero-extended to 16 bits
    function automatic logic [7:0] pick_byte(input logic [W-1:0] w, input logic [3:0] idx);
        logic [15:0] s;
        int ch;
        int b;
        ch = int'(idx) / BPS;
        b  = int'(idx) % BPS;
        s  = '0;
        s[N_BIT-1:0] = w[ch*N_BIT +: N_BIT];
        return (b == 1) ? s[15:8] : s[7:0];
    endfunction

    assign cmd_start = rx_vld && (rx_data == CMD_START) && (state == S_IDLE);
    assign cmd_abort = rx_vld && (rx_data == CMD_ABORT);
    assign streaming = (state == S_CAP) || (state == S_DRAIN);
    // uart_tx needs a cycle to drop tx_rdy, so never issue back-to-back
    assign can_issue = streaming && tx_rdy && !tx_wreq && !cmd_abort;

    // p1: rising edge of the registered ack, sample word already held in dout_p0
    assign edge_cap = ack_p0 && !ack_p1 && (state == S_CAP) && !cmd_abort;

    assign src_word     = ser_busy ? ser_word : fifo_rdata;
    assign src_idx      = ser_busy ? ser_idx : 4'd0;
    assign sample_byte  = pick_byte(src_word, src_idx);
    assign issue_sample = can_issue && hdr_idle && (ser_busy || !fifo_empty);
    assign fifo_pop     = issue_sample && !ser_busy;
    assign fifo_push    = edge_cap && (!fifo_full || fifo_pop);
    assign drain_done   = (state == S_DRAIN) && fifo_empty && !ser_busy && frame_done;

`ifdef ADC_STREAM_FRAME_EN
    logic [1:0] hdr_left;
    logic       csum_sent;
    logic [7:0] csum;
    logic       issue_hdr, issue_csum;

    assign hdr_idle   = (hdr_left == 2'd0);
    assign frame_done = hdr_idle && csum_sent;
    assign issue_hdr  = can_issue && !hdr_idle;
    assign issue_csum = can_issue && hdr_idle && !csum_sent && (state == S_DRAIN)
                        && fifo_empty && !ser_busy;
`else
    assign hdr_idle   = 1'b1;
    assign frame_done = 1'b1;
`endif

    adc_sample_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (cmd_abort),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (dout_p0),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // p0: capture ack level and data in the same cycle
    always_ff @(posedge clk) begin
        dout_p0 <= adc_dout;
        if (fifo_pop) ser_word <= fifo_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rstn_adc  <= 1'b1;
            calib_ena <= 1'b0;
            adc_ena   <= 1'b0;
            ovf       <= 1'b0;
            cnt_sent  <= '0;
            tx_wreq   <= 1'b0;
            tx_wdata  <= '0;
            cyc_cnt   <= '0;
            smp_cnt   <= '0;
            ser_busy  <= 1'b0;
            ser_idx   <= '0;
            ack_p0    <= 1'b0;
            ack_p1    <= 1'b0;
`ifdef ADC_STREAM_FRAME_EN
            hdr_left  <= '0;
            csum_sent <= 1'b0;
            csum      <= '0;
`endif
        end else begin
            ack_p0  <= adc_ack;
            ack_p1  <= ack_p0;
            tx_wreq <= 1'b0;
            if (cmd_abort) begin
                state     <= S_IDLE;
                rstn_adc  <= 1'b1;
                calib_ena <= 1'b0;
                adc_ena   <= 1'b0;
                ser_busy  <= 1'b0;
                ser_idx   <= '0;
`ifdef ADC_STREAM_FRAME_EN
                hdr_left  <= '0;
`endif
            end else begin
                case (state)
                    S_IDLE: if (cmd_start) begin
                        state    <= S_ADCRST;
                        rstn_adc <= 1'b0;
                        cyc_cnt  <= '0;
                        smp_cnt  <= '0;
                        ovf      <= 1'b0;
                        cnt_sent <= '0;
`ifdef ADC_STREAM_FRAME_EN
                        hdr_left  <= 2'd2;
                        csum_sent <= 1'b0;
                        csum      <= '0;
`endif
                    end
                    S_ADCRST: if (cyc_cnt == RST_LAST) begin
                        state     <= S_CAL;
                        rstn_adc  <= 1'b1;
                        calib_ena <= 1'b1;
                        cyc_cnt   <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                    S_CAL: if (cyc_cnt == CAL_LAST) begin
                        state     <= S_CAP;
                        calib_ena <= 1'b0;
                        adc_ena   <= 1'b1;
                        cyc_cnt   <= '0;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                    S_CAP: if (edge_cap) begin
                        if (fifo_full && !fifo_pop) ovf <= 1'b1;
                        if (smp_cnt == LAST_SMP) begin
                            state   <= S_DRAIN;
                            adc_ena <= 1'b0;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                    S_DRAIN: if (drain_done) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end

            // p2: byte issue towards uart_tx
            if (issue_sample) begin
                tx_wreq  <= 1'b1;
                tx_wdata <= sample_byte;
                if (src_idx == LAST_IDX) begin
                    ser_busy <= 1'b0;
                    ser_idx  <= '0;
                    if (cnt_sent != 18'h3FFFF) cnt_sent <= cnt_sent + 18'd1;
                end else begin
                    ser_busy <= 1'b1;
                    ser_idx  <= src_idx + 4'd1;
                end
            end
`ifdef ADC_STREAM_FRAME_EN
            if (issue_sample) csum <= csum ^ sample_byte;
            if (issue_hdr) begin
                tx_wreq  <= 1'b1;
                tx_wdata <= (hdr_left == 2'd2) ? SYNC0 : SYNC1;
                hdr_left <= hdr_left - 2'd1;
            end
            if (issue_csum) begin
                tx_wreq   <= 1'b1;
                tx_wdata  <= csum;
                csum_sent <= 1'b1;
            end
`endif
        end
    end

    assign busy    = (state != S_IDLE);
    assign state_o = state;

endmodule
